psd_arbiter: RTL
================

PSD_ARBITER -- requirements
Module: psd_arbiter

Interface
REQ-001 SHALL have parameter NUM_Requester, default 4: number of requesters sharing one detector.
REQ-002 SHALL have parameter WID_Bitstream, default 8: stream word width, equal to the detector's word width.
REQ-003 SHALL have parameter WID_Compair, default 8: pattern width, equal to the detector's pattern width.
REQ-004 SHALL have parameter WID_Length, default 8: session length field width, in words.
REQ-005 SHALL have parameter LAT_Detect, default 2: cycles from a word on PSA_PSD_bitstream to its position on local_PSA_position.
REQ-006 SHALL have the following ports, clock and reset first; n = NUM_Requester, all vectors packed with requester i at slice i:
  local_PSA_clk  in  1  single clock; all logic on its rising edge.
  local_PSA_reset_n  in  1  asynchronous, active-low reset.
  local_PSA_req  in  n  session request, one bit per requester.
  local_PSA_compair  in  n*WID_Compair  per-requester pattern.
  local_PSA_length  in  n*WID_Length  per-requester word count.
  local_PSA_valid  in  n  per-requester word valid.
  local_PSA_bitstream  in  n*WID_Bitstream  per-requester word.
  PSA_local_grant  out  n  one-hot grant, held for the whole session.
  PSA_local_ready  out  n  word accepted this cycle (winner, STREAM only).
  PSA_local_done  out  n  one-cycle session-complete pulse.
  PSA_local_hit  out  1  a match was found in the last session.
  PSA_local_position  out  WID_Bitstream  first nonzero detector position vector.
  PSA_local_index  out  WID_Length  word index of that first match.
  PSA_local_error  out  1  last session aborted.
  PSA_local_busy  out  1  state != IDLE.
  PSA_PSD_newstream  out  1  detector restart strobe.
  PSA_PSD_compair  out  WID_Compair  pattern to detector.
  PSA_PSD_bitstream  out  WID_Bitstream  word to detector.
  local_PSA_position  in  WID_Bitstream  detector match vector.

Function
REQ-007 SHALL implement states IDLE, LOAD, STREAM, DRAIN, DONE; all outputs registered.
REQ-008 IDLE: when any req bit is high, SHALL select the winner round-robin, searching upward from pointer ptr (wrapping), assert its grant from the next cycle, and enter LOAD.
REQ-009 LOAD (1 cycle): SHALL latch the winner's compair and length, drive PSA_PSD_newstream=1 with PSA_PSD_compair, and clear hit/position/index/error.
REQ-010 If the latched length is 0, SHALL skip from LOAD to DONE with error=1 and SHALL NOT pulse newstream.
REQ-011 STREAM: for exactly length cycles, SHALL drive the winner's ready=1 and forward its word to PSA_PSD_bitstream.
REQ-012 STREAM stall rule: the detector shifts every cycle, so if the winner's valid=0 in any STREAM cycle, the block SHALL set error=1 and go to DONE next cycle.
REQ-013 DRAIN: for LAT_Detect cycles, SHALL drive PSA_PSD_bitstream=0 with ready=0, then enter DONE.
REQ-014 Result capture: with k counting cycles from the first STREAM cycle (k=0), the sample of local_PSA_position at k belongs to word index k-LAT_Detect.
REQ-015 A sample SHALL be used only when 0 <= k-LAT_Detect < length; the first nonzero used sample sets hit=1, position=sample and index=k-LAT_Detect, and later samples SHALL be ignored.
REQ-016 DONE (1 cycle): SHALL pulse done[winner], drop the grant at the end of this cycle, set ptr=winner+1 mod n, and return to IDLE.
REQ-017 hit, position, index and error SHALL hold from DONE until the next LOAD.
REQ-018 Request withdrawal after grant SHALL be ignored; the session runs to DONE or abort.
REQ-019 PSA_PSD_newstream SHALL be 0 and PSA_PSD_bitstream SHALL be 0 in every state except as stated above.
REQ-020 Counters SHALL be WID_Length bits wide, and a length of 2^WID_Length-1 SHALL complete without wrap.

Reset
REQ-021 Reset low SHALL force IDLE immediately, regardless of clock.
REQ-022 Reset low SHALL clear all outputs to 0 and set ptr=0.
REQ-023 Reset asserted mid-session SHALL abort it without a done pulse.
REQ-024 After reset release, the first arbitration SHALL start at requester 0.

Verification
REQ-025 Basic session: LAT_Detect=2; req[1] at t, length=4, valid continuous, detector model returns 8'h04 for word 2 -> grant[1] at t+1, newstream at t+1, ready t+2..t+5, done[1] at t+8, hit=1, position=8'h04, index=2, error=0.
REQ-026 Round-robin: req=4'b1111 held after reset -> grant order 0,1,2,3,0, and each grant SHALL be one-hot.
REQ-027 Stall abort: length=6, valid drops on the 3rd STREAM cycle -> done pulse the next cycle, error=1, no DRAIN, and the next session runs normally.
REQ-028 Zero length and no match: length=0 -> done at LOAD+1 with error=1 and newstream never pulsed; length=3 with all-zero positions -> hit=0, position=0.
REQ-029 Reset mid-STREAM: reset_n low -> outputs 0 asynchronously, no done pulse, ptr=0, and a pending req[2] is granted correctly after release.
REQ-030 Match outside window: a nonzero position at k=LAT_Detect+length (a drain artefact) -> hit=0.

Source files
------------

// File: rtl/psd_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// psd_arbiter : round-robin sharing of one pattern-sequence detector  (rev 1.0)
// ----------------------------------------------------------------------------
module psd_arbiter #(
  parameter int NUM_Requester = 4,
  parameter int WID_Bitstream = 8,
  parameter int WID_Compair   = 8,
  parameter int WID_Length    = 8,
  parameter int LAT_Detect    = 2
) (
  input  logic                                   local_PSA_clk,
  input  logic                                   local_PSA_reset_n,
  input  logic [NUM_Requester-1:0]               local_PSA_req,
  input  logic [NUM_Requester*WID_Compair-1:0]   local_PSA_compair,
  input  logic [NUM_Requester*WID_Length-1:0]    local_PSA_length,
  input  logic [NUM_Requester-1:0]               local_PSA_valid,
  input  logic [NUM_Requester*WID_Bitstream-1:0] local_PSA_bitstream,
  output logic [NUM_Requester-1:0]               PSA_local_grant,
  output logic [NUM_Requester-1:0]               PSA_local_ready,
  output logic [NUM_Requester-1:0]               PSA_local_done,
  output logic                                   PSA_local_hit,
  output logic [WID_Bitstream-1:0]               PSA_local_position,
  output logic [WID_Length-1:0]                  PSA_local_index,
  output logic                                   PSA_local_error,
  output logic                                   PSA_local_busy,
  output logic                                   PSA_PSD_newstream,
  output logic [WID_Compair-1:0]                 PSA_PSD_compair,
  output logic [WID_Bitstream-1:0]               PSA_PSD_bitstream,
  input  logic [WID_Bitstream-1:0]               local_PSA_position
);

  localparam int IDX_W = (NUM_Requester > 1) ? $clog2(NUM_Requester) : 1;
  localparam int LAG_W = (LAT_Detect > 0) ? $clog2(LAT_Detect + 1) : 1;
  localparam logic [LAG_W-1:0]      LAG_MAX    = LAG_W'(LAT_Detect);
  localparam logic [WID_Length-1:0] DRAIN_LAST = (LAT_Detect > 0) ? WID_Length'(LAT_Detect - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           winner_q, winner_d;
  logic [IDX_W-1:0]           ptr_q, ptr_d;
  logic [NUM_Requester-1:0]   grant_q, grant_d;
  logic [NUM_Requester-1:0]   ready_q, ready_d;
  logic [NUM_Requester-1:0]   done_q, done_d;
  logic                       hit_q, hit_d;
  logic [WID_Bitstream-1:0]   pos_q, pos_d;
  logic [WID_Length-1:0]      index_q, index_d;
  logic                       error_q, error_d;
  logic                       busy_q, busy_d;
  logic                       newstream_q, newstream_d;
  logic [WID_Compair-1:0]     compair_q, compair_d;
  logic [WID_Length-1:0]      len_q, len_d;
  logic [WID_Length-1:0]      cnt_q, cnt_d;
  logic [LAG_W-1:0]           lag_q, lag_d;
  logic [WID_Length-1:0]      cap_q, cap_d;

  logic                       pick_found;
  logic [IDX_W-1:0]           pick_idx;
  logic [WID_Length-1:0]      pick_len;
  logic [WID_Compair-1:0]     pick_cmp;
  logic                       win_valid;
  logic [WID_Bitstream-1:0]   win_word;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
    int j;
    j = int'(base) + off;
    if (j >= NUM_Requester) j = j - NUM_Requester;
    return IDX_W'(j);
  endfunction

  function automatic logic [NUM_Requester-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_Requester-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_Requester; i++) begin
      if (!pick_found && local_PSA_req[rr_idx(ptr_q, i)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx(ptr_q, i);
      end
    end
  end

  assign pick_len  = local_PSA_length[pick_idx*WID_Length +: WID_Length];
  assign pick_cmp  = local_PSA_compair[pick_idx*WID_Compair +: WID_Compair];
  assign win_valid = local_PSA_valid[winner_q];
  assign win_word  = local_PSA_bitstream[winner_q*WID_Bitstream +: WID_Bitstream];

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    ready_d     = ready_q;
    done_d      = '0;
    hit_d       = hit_q;
    pos_d       = pos_q;
    index_d     = index_q;
    error_d     = error_q;
    newstream_d = 1'b0;
    compair_d   = compair_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    lag_d       = lag_q;
    cap_d       = cap_q;

    // Samples are word-aligned once LAT_Detect cycles have passed; the window
    // closes exactly at the last DRAIN cycle, so DONE never samples.
    if (state_q == S_STREAM || state_q == S_DRAIN) begin
      if (lag_q != LAG_MAX) begin
        lag_d = lag_q + 1'b1;
      end else begin
        cap_d = cap_q + 1'b1;
        if (!hit_q && local_PSA_position != '0) begin
          hit_d   = 1'b1;
          pos_d   = local_PSA_position;
          index_d = cap_q;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          winner_d    = pick_idx;
          grant_d     = onehot(pick_idx);
          compair_d   = pick_cmp;
          len_d       = pick_len;
          newstream_d = (pick_len != '0);
          hit_d       = 1'b0;
          pos_d       = '0;
          index_d     = '0;
          error_d     = 1'b0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d = '0;
        lag_d = '0;
        cap_d = '0;
        if (len_q == '0) begin
          error_d = 1'b1;
          done_d  = onehot(winner_q);
          state_d = S_DONE;
        end else begin
          ready_d = onehot(winner_q);
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (!win_valid) begin
          error_d = 1'b1;
          ready_d = '0;
          done_d  = onehot(winner_q);
          state_d = S_DONE;
        end else if (cnt_q == len_q - 1'b1) begin
          ready_d = '0;
          cnt_d   = '0;
          if (LAT_Detect == 0) begin
            done_d  = onehot(winner_q);
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          done_d  = onehot(winner_q);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        grant_d = '0;
        ptr_d   = rr_idx(winner_q, 1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge local_PSA_clk or negedge local_PSA_reset_n) begin
    if (!local_PSA_reset_n) begin
      state_q     <= S_IDLE;
      winner_q    <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      ready_q     <= '0;
      done_q      <= '0;
      hit_q       <= 1'b0;
      pos_q       <= '0;
      index_q     <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      newstream_q <= 1'b0;
      compair_q   <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      lag_q       <= '0;
      cap_q       <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      pos_q       <= pos_d;
      index_q     <= index_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      newstream_q <= newstream_d;
      compair_q   <= compair_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      lag_q       <= lag_d;
      cap_q       <= cap_d;
    end
  end

  assign PSA_local_grant    = grant_q;
  assign PSA_local_ready    = ready_q;
  assign PSA_local_done     = done_q;
  assign PSA_local_hit      = hit_q;
  assign PSA_local_position = pos_q;
  assign PSA_local_index    = index_q;
  assign PSA_local_error    = error_q;
  assign PSA_local_busy     = busy_q;
  assign PSA_PSD_newstream  = newstream_q;
  assign PSA_PSD_compair    = compair_q;
  // The word accepted this cycle goes straight to the detector so that word k
  // and its ready share a cycle; the select itself is the registered ready.
  assign PSA_PSD_bitstream  = (|ready_q) ? win_word : '0;

endmodule
`default_nettype wire
